decode_stage: RTL
=================

# decode_stage

Pipeline decode stage directly downstream of instruction fetch. It contains the fetch/decode pipeline register for the fetched instruction, with stall and flush control. It also holds the 15-entry architectural register file (R0–R14), with R15 reads returning PC+8, and the immediate extend unit. Operands, extended immediate and read addresses go to the execute pipeline register; register-file writes come back from writeback.

## Interface
- BITS, 32, datapath width of PC, operands and results
- NREGS, 15, physical registers R0..R14; R15 is never stored

- CLK  input  1  rising-edge clock
- RESET  input  1  asynchronous, active-low reset
- InstrF  input  BITS  instruction from fetch
- PCPlus4F  input  BITS  fetch PC+4; equals PC(InstrD)+8 while InstrD is in decode
- StallD  input  1  hold decode register
- FlushD  input  1  replace decode register with bubble
- RegSrcD  input  2  bit0: RA1 = 15 instead of Instr[19:16]; bit1: RA2 = Instr[15:12] instead of Instr[3:0]
- ImmSrcD  input  2  extend mode select
- RegWriteW  input  1  writeback enable
- WA3W  input  4  writeback address
- ResultW  input  BITS  writeback data
- InstrD  output  BITS  registered instruction
- ValidD  output  1  InstrD holds a real instruction
- RA1D, RA2D  output  4  selected read addresses, for the hazard unit
- RD1D, RD2D  output  BITS  read operands
- ExtImmD  output  BITS  extended immediate

## Operation
- Decode register, on the rising CLK edge, in priority order:
  - FlushD: InstrD←0, ValidD←0.
  - else StallD: hold InstrD and ValidD.
  - else: InstrD←InstrF, ValidD←1.
- FlushD wins over StallD when both are asserted.
- Register file write: on the rising CLK edge, if RegWriteW and WA3W≠15, R[WA3W]←ResultW. A write with WA3W=15 is silently dropped; PC writes reach fetch by another path.
- StallD and FlushD do not gate register-file writes.
- Reads are combinational from InstrD:
  - RA1D = RegSrcD[0] ? 15 : InstrD[19:16].
  - RA2D = RegSrcD[1] ? InstrD[15:12] : InstrD[3:0].
  - RDn = PCPlus4F when RAn=15; otherwise R[RAn].
- Extend, combinational from InstrD:
  - ImmSrcD 00: zero-extend InstrD[7:0].
  - ImmSrcD 01: zero-extend InstrD[11:0].
  - ImmSrcD 10: sign-extend InstrD[23:0], shifted left 2.
  - ImmSrcD 11: 0.
- Reset (RESET low): asynchronous; InstrD=0, ValidD=0, R0..R14=0 immediately. RD outputs follow combinationally, with RD=PCPlus4F for address 15.
- Reset deasserting mid-stream: the first edge after deassertion behaves as a normal edge.

## Timing
- InstrF to InstrD: 1 cycle latency.
- RD1D, RD2D, ExtImmD, RA1D, RA2D: valid in the same cycle as InstrD, combinational after clock-to-q.
- Register write is visible on reads in the cycle after the write edge; same-cycle visibility depends on the Configuration macro below.
- Stall held N cycles keeps InstrD constant for N cycles. RD outputs may still change if writeback updates the addressed register.
- Flush produces exactly one bubble per asserted cycle.

## Configuration
- DECODE_BYPASS_EN
  - Defined: write-through bypass. If RegWriteW && WA3W==RAn && RAn≠15, RDn=ResultW in the same cycle the write is presented.
  - Undefined: RDn returns the stored value, i.e. the pre-write value that cycle. The hazard unit must then stall one extra cycle on a decode/writeback same-register conflict.

## Test plan
- Reset: pulse RESET low mid-cycle with InstrF=0xE0812003 registered → InstrD=0, ValidD=0 immediately, without waiting for CLK. All registers read 0 afterwards.
- Pipeline, stall and flush:
  - InstrF=0xE0812003 for one edge → InstrD=0xE0812003, ValidD=1, RA1D=1, RA2D=3.
  - StallD=1 for 3 edges with a changing InstrF → InstrD unchanged.
  - FlushD=StallD=1 → InstrD=0, ValidD=0.
- Write/read: write R1=0x11111111 and R3=0x22222222, then decode 0xE0812003 → RD1D=0x11111111, RD2D=0x22222222.
  - Write with WA3W=15, ResultW=0xDEAD → no register changes.
- R15 read: RegSrcD=01 with PCPlus4F=0x00000108 → RA1D=15, RD1D=0x00000108.
- Extend: InstrD=0xEA000FFE with ImmSrcD=10 → ExtImmD=0x00003FF8; InstrD=0xEAFFFFFE → 0xFFFFFFF8.
  - InstrD=0xE3A000AB with ImmSrcD=00 → 0x000000AB; 0xE5901ABC with ImmSrcD=01 → 0x00000ABC.
- Bypass: R1 holds 5; present RegWriteW=1, WA3W=1, ResultW=9 while InstrD reads R1.
  - With DECODE_BYPASS_EN: RD1D=9 that cycle.
  - Without: RD1D=5 that cycle.
  - Both builds: RD1D=9 the next cycle.

Source files
------------

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - fetch/decode pipeline register, R0..R14 register file with R15=PC+8, immediate extend
// Optional build macro: DECODE_BYPASS_EN (write-through from writeback to the read ports).
module decode_stage #(
    parameter int BITS  = 32,
    parameter int NREGS = 15
) (
    input  logic            CLK_i,
    input  logic            RESET_i,
    input  logic [BITS-1:0] InstrF_i,
    input  logic [BITS-1:0] PCPlus4F_i,
    input  logic            StallD_i,
    input  logic            FlushD_i,
    input  logic [1:0]      RegSrcD_i,
    input  logic [1:0]      ImmSrcD_i,
    input  logic            RegWriteW_i,
    input  logic [3:0]      WA3W_i,
    input  logic [BITS-1:0] ResultW_i,
    output logic [BITS-1:0] InstrD_o,
    output logic            ValidD_o,
    output logic [3:0]      RA1D_o,
    output logic [3:0]      RA2D_o,
    output logic [BITS-1:0] RD1D_o,
    output logic [BITS-1:0] RD2D_o,
    output logic [BITS-1:0] ExtImmD_o
);

    logic [BITS-1:0] instr_q, instr_d;
    logic            valid_q, valid_d;
    logic [BITS-1:0] rf_q [NREGS];

    // Flush takes priority over stall so a squashed instruction never lingers.
    always_comb begin
        instr_d = instr_q;
        valid_d = valid_q;
        if (FlushD_i) begin
            instr_d = '0;
            valid_d = 1'b0;
        end else if (!StallD_i) begin
            instr_d = InstrF_i;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge CLK_i or negedge RESET_i) begin
        if (!RESET_i) begin
            instr_q <= '0;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            valid_q <= valid_d;
        end
    end

    // R15 is not stored; writes to it are steered to fetch elsewhere.
    always_ff @(posedge CLK_i or negedge RESET_i) begin
        if (!RESET_i) begin
            for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
        end else if (RegWriteW_i && (WA3W_i != 4'd15)) begin
            rf_q[WA3W_i] <= ResultW_i;
        end
    end

    always_comb begin
        RA1D_o = RegSrcD_i[0] ? 4'd15 : instr_q[19:16];
        RA2D_o = RegSrcD_i[1] ? instr_q[15:12] : instr_q[3:0];
    end

    always_comb begin
        if (RA1D_o == 4'd15)
            RD1D_o = PCPlus4F_i;
`ifdef DECODE_BYPASS_EN
        else if (RegWriteW_i && (WA3W_i == RA1D_o))
            RD1D_o = ResultW_i;
`endif
        else
            RD1D_o = rf_q[RA1D_o];
    end

    always_comb begin
        if (RA2D_o == 4'd15)
            RD2D_o = PCPlus4F_i;
`ifdef DECODE_BYPASS_EN
        else if (RegWriteW_i && (WA3W_i == RA2D_o))
            RD2D_o = ResultW_i;
`endif
        else
            RD2D_o = rf_q[RA2D_o];
    end

    always_comb begin
        case (ImmSrcD_i)
            2'b00:   ExtImmD_o = {{(BITS-8){1'b0}}, instr_q[7:0]};
            2'b01:   ExtImmD_o = {{(BITS-12){1'b0}}, instr_q[11:0]};
            2'b10:   ExtImmD_o = {{(BITS-26){instr_q[23]}}, instr_q[23:0], 2'b00};
            default: ExtImmD_o = '0;
        endcase
    end

    assign InstrD_o = instr_q;
    assign ValidD_o = valid_q;

endmodule
